// File: rtl/sequency_reorder.sv
// sequency_reorder: ping-pong frame buffer that takes FWHT coefficients in
// natural (Hadamard) order and emits them in sequency (Walsh) order, tagged
// with the sequency index. The write side scatters each sample to its
// sequency position, and the read side sweeps the bank linearly.
// Optional framing check: define SEQUENCY_REORDER_CHECK_EN to add i_last and
// the sticky o_frame_err flag. Without it, frames are delimited by count.
module sequency_reorder #(
   parameter int L_WIDTH = 6,
   parameter int D_WIDTH = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [D_WIDTH-1:0] i_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [D_WIDTH-1:0] o_data,
   output logic [L_WIDTH-1:0] o_index,
   output logic               o_last
`ifdef SEQUENCY_REORDER_CHECK_EN
   ,
   input  logic               i_last,
   output logic               o_frame_err
`endif
);

   localparam int N = 2 ** L_WIDTH;

   logic [D_WIDTH-1:0] mem [2*N];
   logic [1:0]         full;
   logic               wr_bank;
   logic               rd_bank;
   logic [L_WIDTH-1:0] wr_cnt;
   logic [L_WIDTH-1:0] rd_cnt;
   logic               wr_fire;
   logic               wr_end;
   logic               wr_drop;
   logic               rd_fetch;
   logic               rd_end;

   // Natural index -> sequency position: gray-to-binary of the bit-reversed index.
   function automatic logic [L_WIDTH-1:0] seq_addr(input logic [L_WIDTH-1:0] k);
      logic [L_WIDTH-1:0] g;
      logic [L_WIDTH-1:0] b;
      for (int i = 0; i < L_WIDTH; i++) g[i] = k[L_WIDTH-1-i];
      b[L_WIDTH-1] = g[L_WIDTH-1];
      for (int i = L_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // Ready depends on registered full flags only, never on i_valid.
   assign o_ready  = !full[wr_bank];
   assign wr_fire  = i_valid && o_ready;
   // Fetch whenever the output register is empty or draining this cycle.
   assign rd_fetch = full[rd_bank] && (!o_valid || i_ready);
   assign rd_end   = rd_fetch && (rd_cnt == '1);

   // Decode end-of-frame and early-termination of the frame being written.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wr_end  = wr_fire && (wr_cnt == '1);
      wr_drop = 1'b0;
`ifdef SEQUENCY_REORDER_CHECK_EN
      wr_drop = wr_fire && i_last && (wr_cnt != '1);
`endif
   end

   // Scatter each accepted sample to its sequency slot in the write bank.
   // NOTE: the storage array has no reset; full flags alone say what is valid.
   always_ff @(posedge i_clk) begin
      if (wr_fire) mem[{wr_bank, seq_addr(wr_cnt)}] <= i_data;
   end

   // Bank ownership: the writer fills a bank, the reader releases it.
   // A bank is released once its last word has been fetched, since the output
   // register then holds that word; this keeps o_ready high across frames.
   // Clear is written after set so a (never legal) same-bank collision frees it.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         full    <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_cnt  <= '0;
         rd_cnt  <= '0;
      end else begin
         if (wr_fire) begin
            if (wr_drop) wr_cnt <= '0;
            else         wr_cnt <= wr_cnt + 1'b1;
            if (wr_end) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
            end
         end
         if (rd_fetch) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_end) begin
               full[rd_bank] <= 1'b0;
               rd_bank       <= ~rd_bank;
            end
         end
      end
   end

   // Output register: load on fetch, empty when consumed with nothing behind it.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_index <= '0;
         o_last  <= 1'b0;
      end else if (rd_fetch) begin
         o_valid <= 1'b1;
         o_data  <= mem[{rd_bank, rd_cnt}];
         o_index <= rd_cnt;
         o_last  <= (rd_cnt == '1);
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

`ifdef SEQUENCY_REORDER_CHECK_EN
   // Sticky framing error: i_last must coincide exactly with the N-th beat.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_frame_err <= 1'b0;
      end else if (wr_fire && (i_last != (wr_cnt == '1))) begin
         o_frame_err <= 1'b1;
      end
   end
`endif

   // Writer completing and reader releasing the same bank means ownership broke.
   a_bank_collision : assert property (@(posedge i_clk) disable iff (i_reset)
      !(wr_end && rd_end && (wr_bank == rd_bank)));

endmodule

// File: tb/tb_sequency_reorder.sv
// Scoreboard bench for sequency_reorder. The reference order is derived from
// the sign-change count of each Hadamard row, independent of the address map.
module tb_sequency_reorder;

   localparam int L = 3;
   localparam int D = 16;
   localparam int N = 1 << L;

   typedef struct packed {
      logic [D-1:0] data;
      logic [L-1:0] idx;
      logic         last;
   } exp_t;

   logic         i_clk   = 1'b0;
   logic         i_reset = 1'b1;
   logic         i_valid = 1'b0;
   logic         i_ready = 1'b0;
   logic         i_last  = 1'b0;
   logic [D-1:0] i_data  = '0;
   logic         o_ready;
   logic         o_valid;
   logic         o_last;
   logic [D-1:0] o_data;
   logic [L-1:0] o_index;
`ifdef SEQUENCY_REORDER_CHECK_EN
   logic         o_frame_err;
`endif

   int           n_checks = 0;
   int           n_fail   = 0;
   int           seq_of[N];
   exp_t         exp_q[$];
   logic [D-1:0] frame_q[$];
   logic         exp_err    = 1'b0;
   logic         prev_stall = 1'b0;
   exp_t         held;
   logic         rand_ready  = 1'b0;
   logic         ready_const = 1'b1;

   sequency_reorder #(.L_WIDTH(L), .D_WIDTH(D)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_index (o_index),
      .o_last  (o_last)
`ifdef SEQUENCY_REORDER_CHECK_EN
      ,
      .i_last      (i_last),
      .o_frame_err (o_frame_err)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sequency of Hadamard row k = number of sign changes along the row.
   function automatic int sequency(input int k);
      int changes = 0;
      int prev = 0;
      int s;
      for (int j = 0; j < N; j++) begin
         s = $countones(k & j) % 2;
         if (j > 0 && s != prev) changes++;
         prev = s;
      end
      return changes;
   endfunction

   // Reference model of one accepted input beat.
   function automatic void accept(input logic [D-1:0] d, input logic last);
      logic         drop = 1'b0;
      logic [D-1:0] ord[N];
      exp_t         e;
`ifdef SEQUENCY_REORDER_CHECK_EN
      if (last != (frame_q.size() == N - 1)) exp_err = 1'b1;
      if (last && frame_q.size() != N - 1) drop = 1'b1;
`endif
      if (drop) begin
         frame_q.delete();
      end else begin
         frame_q.push_back(d);
         if (frame_q.size() == N) begin
            for (int k = 0; k < N; k++) ord[seq_of[k]] = frame_q[k];
            for (int s = 0; s < N; s++) begin
               e.data = ord[s];
               e.idx  = L'(s);
               e.last = (s == N - 1);
               exp_q.push_back(e);
            end
            frame_q.delete();
         end
      end
   endfunction

   // Monitor: samples on the falling edge what the next rising edge will see.
   always @(negedge i_clk) begin
      exp_t e;
      if (i_reset) begin
         exp_q.delete();
         frame_q.delete();
         exp_err    = 1'b0;
         prev_stall = 1'b0;
      end else begin
`ifdef SEQUENCY_REORDER_CHECK_EN
         check("frame_err", 64'(o_frame_err), 64'(exp_err));
`endif
         if (prev_stall)
            check("stall_hold", {o_valid, o_data, o_index, o_last}, {1'b1, held});
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 64'(o_index), 64'hFFFF);
            end else begin
               e = exp_q.pop_front();
               check("sample", {o_data, o_index, o_last}, e);
            end
         end
         prev_stall = o_valid && !i_ready;
         held       = {o_data, o_index, o_last};
         if (i_valid && o_ready) accept(i_data, i_last);
      end
   end

   // Downstream ready: constant or random at 30% duty.
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         i_ready = rand_ready ? ($urandom_range(0, 99) < 30) : ready_const;
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_beat(input logic [D-1:0] d, input logic last, output int waits);
      logic acc;
      waits   = 0;
      i_valid = 1'b1;
      i_data  = d;
      i_last  = last;
      forever begin
         acc = o_ready;
         tick();
         if (acc) break;
         waits++;
         if (waits > 500) begin
            check("beat_timeout", 64'(waits), 64'(0));
            break;
         end
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   task automatic send_frame(input int beats, input int last_at, input bit seq_data, output int stalls);
      int w;
      stalls = 0;
      for (int k = 0; k < beats; k++) begin
         drive_beat(seq_data ? D'(k) : D'($urandom), (k == last_at), w);
         stalls += w;
      end
   endtask

   task automatic drain();
      int g = 0;
      while ((exp_q.size() != 0 || o_valid) && g < 2000) begin
         tick();
         g++;
      end
      check("drain", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      tick();
      tick();
      i_reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int st;
      int tbl[N] = '{0, 4, 6, 2, 3, 7, 5, 1};
      logic [L+D+1:0] ev;
      for (int k = 0; k < N; k++) seq_of[k] = sequency(k);

      // Reset state.
      do_reset();
      @(negedge i_clk);
      check("reset_valid", 64'(o_valid), 64'(0));
      check("reset_ready", 64'(o_ready), 64'(1));
      check("reset_out", {o_last, o_index, o_data}, 64'(0));

      // Order check with data = natural index, plus latency.
      send_frame(N, N - 1, 1'b1, st);
      @(negedge i_clk);
      check("latency_idle", 64'(o_valid), 64'(0));
      tick();
      for (int s = 0; s < N; s++) begin
         @(negedge i_clk);
         ev = {1'b1, L'(s), (s == N - 1), D'(tbl[s])};
         check("order", {o_valid, o_index, o_last, o_data}, ev);
         tick();
      end
      drain();

      // Streaming: four back-to-back frames, output must be gapless.
      fork
         begin
            int tot = 0;
            int w;
            for (int f = 0; f < 4; f++) begin
               send_frame(N, N - 1, 1'b0, w);
               tot += w;
            end
            check("stream_ready", 64'(tot), 64'(0));
         end
         begin
            int g = 0;
            @(negedge i_clk);
            while (!o_valid && g < 100) begin
               @(negedge i_clk);
               g++;
            end
            check("stream_start", 64'(o_valid), 64'(1));
            for (int i = 1; i < 4 * N; i++) begin
               @(negedge i_clk);
               check("stream_gapless", 64'(o_valid), 64'(1));
            end
         end
      join
      drain();

      // Backpressure: fill both banks with the sink stalled, then random ready.
      ready_const = 1'b0;
      tick();
      tick();
      send_frame(N, N - 1, 1'b0, st);
      send_frame(N, N - 1, 1'b0, st);
      check("bp_fill_stalls", 64'(st), 64'(0));
      @(negedge i_clk);
      check("bp_ready_low", 64'(o_ready), 64'(0));
      check("bp_valid_high", 64'(o_valid), 64'(1));
      rand_ready = 1'b1;
      send_frame(N, N - 1, 1'b0, st);
      send_frame(N, N - 1, 1'b0, st);
      drain();
      rand_ready  = 1'b0;
      ready_const = 1'b1;
      tick();

      // Reset mid-frame: one full frame, then 5 beats of the next.
      send_frame(N, N - 1, 1'b0, st);
      send_frame(5, -1, 1'b0, st);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      @(negedge i_clk);
      check("midrst_valid", 64'(o_valid), 64'(0));
      check("midrst_ready", 64'(o_ready), 64'(1));
      send_frame(N, N - 1, 1'b0, st);
      drain();

`ifdef SEQUENCY_REORDER_CHECK_EN
      // Early i_last on the 5th beat drops the partial frame.
      send_frame(5, 4, 1'b0, st);
      @(negedge i_clk);
      check("err_set", 64'(o_frame_err), 64'(1));
      for (int i = 0; i < 4; i++) tick();
      @(negedge i_clk);
      check("partial_no_output", 64'(o_valid), 64'(0));
      send_frame(N, N - 1, 1'b0, st);
      drain();
      check("err_sticky", 64'(o_frame_err), 64'(1));
      do_reset();
      @(negedge i_clk);
      check("err_cleared", 64'(o_frame_err), 64'(0));
`endif

      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
